mips_io_port: RTL

Responder for the multicycle control unit's `in`/`out` instructions. Opcode 4'b1100 with funk==1 reads external input into a register; otherwise it writes a register to external output. The block buffers CPU output words in a DEPTH-entry FIFO and drains them to an external consumer over a valid/ready handshake. It buffers external input words in a second DEPTH-entry FIFO that the CPU pops during the `in` state. The CPU never stalls, so the block is always ready on the CPU side and reports overflow/underflow through sticky flags.

---
 rtl/mips_io_port.sv | 104 ++++++++++
 1 files changed

// File: rtl/mips_io_port.sv
// rtl/mips_io_port.sv - in/out instruction responder with CPU-side output and input FIFOs
// The CPU side never stalls: dropped writes and empty reads raise sticky flags instead.
module mips_io_port #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             OutputWrite,
    input  logic [WIDTH-1:0] OutData,
    input  logic             InputRead,
    output logic [WIDTH-1:0] InData,
    output logic             InEmpty,
    output logic             OutFull,
    output logic             OutOverflow,
    output logic             InUnderflow,
    input  logic [WIDTH-1:0] ext_in_data,
    input  logic             ext_in_valid,
    output logic             ext_in_ready,
    output logic [WIDTH-1:0] ext_out_data,
    output logic             ext_out_valid,
    input  logic             ext_out_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] out_mem_q [DEPTH];
    logic [WIDTH-1:0] in_mem_q  [DEPTH];

    logic [PW-1:0] out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
    logic [PW-1:0] in_wptr_q,  in_wptr_d,  in_rptr_q,  in_rptr_d;
    logic [CW-1:0] out_cnt_q,  out_cnt_d,  in_cnt_q,   in_cnt_d;
    logic          out_ovf_q,  out_ovf_d,  in_unf_q,   in_unf_d;
    logic          out_push, out_pop, in_push, in_pop;

    always_comb begin
        out_wptr_d = out_wptr_q;
        out_rptr_d = out_rptr_q;
        out_cnt_d  = out_cnt_q;
        in_wptr_d  = in_wptr_q;
        in_rptr_d  = in_rptr_q;
        in_cnt_d   = in_cnt_q;

        ext_in_ready = !Reset && (in_cnt_q != FULL);

        // A pop frees the slot in the same edge, so a full FIFO still takes the write.
        out_pop  = !Reset && (out_cnt_q != '0) && ext_out_ready;
        out_push = !Reset && OutputWrite && ((out_cnt_q != FULL) || out_pop);
        in_push  = ext_in_valid && ext_in_ready;
        in_pop   = !Reset && InputRead && (in_cnt_q != '0);

        out_ovf_d = out_ovf_q | (!Reset && OutputWrite && !out_push);
        in_unf_d  = in_unf_q  | (!Reset && InputRead && (in_cnt_q == '0));

        if (out_push) out_wptr_d = out_wptr_q + PW'(1);
        if (out_pop)  out_rptr_d = out_rptr_q + PW'(1);
        if (out_push && !out_pop)      out_cnt_d = out_cnt_q + CW'(1);
        else if (!out_push && out_pop) out_cnt_d = out_cnt_q - CW'(1);

        if (in_push) in_wptr_d = in_wptr_q + PW'(1);
        if (in_pop)  in_rptr_d = in_rptr_q + PW'(1);
        if (in_push && !in_pop)      in_cnt_d = in_cnt_q + CW'(1);
        else if (!in_push && in_pop) in_cnt_d = in_cnt_q - CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            out_wptr_q <= '0;
            out_rptr_q <= '0;
            out_cnt_q  <= '0;
            in_wptr_q  <= '0;
            in_rptr_q  <= '0;
            in_cnt_q   <= '0;
            out_ovf_q  <= 1'b0;
            in_unf_q   <= 1'b0;
        end else begin
            out_wptr_q <= out_wptr_d;
            out_rptr_q <= out_rptr_d;
            out_cnt_q  <= out_cnt_d;
            in_wptr_q  <= in_wptr_d;
            in_rptr_q  <= in_rptr_d;
            in_cnt_q   <= in_cnt_d;
            out_ovf_q  <= out_ovf_d;
            in_unf_q   <= in_unf_d;
        end
    end

    // Storage is not reset; counts gate everything that reads it.
    always_ff @(posedge CLK) begin
        if (out_push) out_mem_q[out_wptr_q] <= OutData;
        if (in_push)  in_mem_q[in_wptr_q]   <= ext_in_data;
    end

    assign ext_out_data  = out_mem_q[out_rptr_q];
    assign ext_out_valid = (out_cnt_q != '0);
    assign InData        = (in_cnt_q != '0) ? in_mem_q[in_rptr_q] : '0;
    assign InEmpty       = (in_cnt_q == '0);
    assign OutFull       = (out_cnt_q == FULL);
    assign OutOverflow   = out_ovf_q;
    assign InUnderflow   = in_unf_q;

endmodule
